// File: rtl/uart_tx_stream.sv
// ----------------------------------------------------------------------------
// uart_tx_stream
//
// Buffered UART transmitter. Parallel words are written into a small circular
// FIFO and serialised onto tx_out as: start bit (0), DATA_WIDTH data bits
// LSB-first, an optional even/odd parity bit, and one or two stop bits (1).
// Each line bit is held for CLKS_PER_BIT clock cycles. When a frame ends and
// another word is waiting, the next start bit follows with no idle bit.
//
// Parameters
//   DATA_WIDTH    data bits per frame (5..9)
//   FIFO_DEPTH    transmit FIFO entries (power of two, >= 2)
//   CLKS_PER_BIT  clock cycles per line bit (>= 1)
//
// Ports
//   UCLK           in   sole clock, rising edge
//   reset          in   asynchronous, active-high reset
//   data_valid     in   write strobe; word is taken when data_valid && ready
//   parallel_data  in   word to transmit
//   parity_en      in   1 = insert parity bit          (sampled at pop time)
//   parity_odd     in   1 = odd parity, 0 = even       (sampled at pop time)
//   two_stop       in   1 = two stop bits, 0 = one     (sampled at pop time)
//   ready          out  FIFO not full (registered)
//   tx_out         out  serial line, idle high (registered)
//   busy           out  frame in progress
//   fifo_count     out  words currently held in the FIFO
//   overflow       out  one-cycle pulse after a strobe that found ready=0
// ----------------------------------------------------------------------------
module uart_tx_stream #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                          UCLK,
    input  logic                          reset,
    input  logic                          data_valid,
    input  logic [DATA_WIDTH-1:0]         parallel_data,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          two_stop,
    output logic                          ready,
    output logic                          tx_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    // ------------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------------
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // A one-cycle bit time still needs a 1-bit timer so the compare is legal.
    localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    // ------------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;
    logic                  ready_q,  ready_d;
    logic                  overflow_q, overflow_d;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;

    assign head = mem_q[rd_ptr_q];

    // NOTE: every signal assigned in an always_comb gets a default at the top,
    // so no path through the block leaves it unassigned and infers a latch.
    always_comb begin
        // A full FIFO rejects the write even if a pop frees a slot this cycle:
        // acceptance depends only on the registered ready.
        push       = data_valid && ready_q;
        overflow_d = data_valid && !ready_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        // Pointers wrap naturally because the depth is a power of two.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        ready_d = (count_d != FULL_COUNT);
    end

    // NOTE: the data array has no reset; emptiness is defined by the pointers
    // and the count, so clearing the storage itself would only add reset fan-out.
    always_ff @(posedge UCLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= parallel_data;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, regardless of block ordering.
    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------------
    state_e                state_q,    state_d;
    logic [TMR_W-1:0]      tmr_q,      tmr_d;      // cycles within a bit
    logic [IDX_W-1:0]      idx_q,      idx_d;      // data bit / stop bit index
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;
    logic                  par_q,      par_d;      // parity bit for this frame
    logic                  par_en_q,   par_en_d;
    logic                  two_stop_q, two_stop_d;
    logic                  tx_q,       tx_d;
    logic                  bit_done;
    logic                  load;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        par_en_d   = par_en_q;
        two_stop_d = two_stop_q;
        load       = 1'b0;
        pop        = 1'b0;
        tx_d       = 1'b1;

        bit_done = (tmr_q == TMR_LAST);

        // Every state change happens on a bit boundary, so wrapping the timer
        // at the end of each bit also clears it on every transition.
        tmr_d = (state_q == IDLE || bit_done) ? '0 : tmr_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    load = 1'b1;
                end
            end

            START: begin
                if (bit_done) begin
                    state_d = DATA;
                end
            end

            DATA: begin
                if (bit_done) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end

            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                end
            end

            STOP: begin
                if (bit_done) begin
                    if (two_stop_q && (idx_q == '0)) begin
                        // Second stop bit: stay in STOP for one more bit time.
                        idx_d = IDX_W'(1);
                    end else if (count_q != '0) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Start a new frame: take the head word and freeze the line format.
        if (load) begin
            pop        = 1'b1;
            shift_d    = head;
            par_en_d   = parity_en;
            two_stop_d = two_stop;
            par_d      = (^head) ^ parity_odd;
            idx_d      = '0;
            state_d    = START;
        end

        // The line level is registered, so it is derived from the next state.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            par_en_q   <= par_en_d;
            two_stop_q <= two_stop_d;
            tx_q       <= tx_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ready      = ready_q;
    assign tx_out     = tx_q;
    assign busy       = (state_q != IDLE);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/uart_tx_stream.md
# uart_tx_stream

Buffered, parametrised UART transmitter: the next-generation transmit path for the APB-UART bridge. It accepts parallel words into an internal FIFO and serialises each word onto a single line. Each frame is a start bit, DATA_WIDTH data bits LSB-first, an optional even/odd parity bit, and 1 or 2 stop bits. Each bit is held for CLKS_PER_BIT clock cycles. It sits between the APB register interface (write side) and the UART pad (tx_out).

## Interface
- DATA_WIDTH, 8: data bits per frame, legal range 5..9.
- FIFO_DEPTH, 4: transmit FIFO entries, power of two, ≥2.
- CLKS_PER_BIT, 16: UCLK cycles per line bit, ≥1.
- UCLK  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_valid  in  1  write strobe; word is written when data_valid && ready.
- parallel_data  in  DATA_WIDTH  word to transmit.
- parity_en  in  1  1 = insert parity bit.
- parity_odd  in  1  1 = odd parity, 0 = even parity (ignored when parity_en=0).
- two_stop  in  1  1 = two stop bits, 0 = one stop bit.
- ready  out  1  FIFO not full (registered; equals fifo_count != FIFO_DEPTH).
- tx_out  out  1  serial line, idle high, registered.
- busy  out  1  frame in progress (state != IDLE).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words held in FIFO.
- overflow  out  1  one-cycle pulse when data_valid=1 and ready=0 (word dropped).

## Operation
- FIFO: circular buffer with wrapping read and write pointers and a separate occupancy counter.
  - A write and a pop in the same cycle leave the count unchanged.
  - When ready=0, a write is rejected even if a pop occurs in the same cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_out=1. If fifo_count≠0, pop the head word into the shift register, latch parity_en, parity_odd and two_stop, compute parity, and go to START.
  - START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx_out=shift[0], shift right every CLKS_PER_BIT cycles. After DATA_WIDTH bits, go to PARITY if the latched parity_en=1, else STOP.
  - PARITY: tx_out = (^word) XOR parity_odd, held for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles (2×CLKS_PER_BIT if two_stop latched). At the end, if fifo_count≠0, pop and go directly to START with no idle bit; else go to IDLE.
- Counters:
  - Bit-time counter: 0..CLKS_PER_BIT-1, cleared on every state change.
  - Bit index counter: 0..DATA_WIDTH-1; in STOP it counts 0..1.
- Configuration inputs are sampled only at pop time. Changes mid-frame do not affect the current frame.
- Reset values (asynchronous): FIFO emptied, pointers=0, state=IDLE, tx_out=1, busy=0, ready=1, fifo_count=0, overflow=0.
- A reset asserted mid-frame aborts the frame immediately: tx_out returns to 1 and the buffered words are discarded.

## Timing
- Write accepted at edge N gives fifo_count=1 after edge N.
- If idle, the pop occurs at edge N+1. tx_out falls (start bit) after edge N+1 and busy=1 from the same edge.
- Frame length in cycles: CLKS_PER_BIT × (1 + DATA_WIDTH + parity_en + 1 + two_stop).
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- ready and fifo_count update on the edge after the write or pop. overflow is asserted in the cycle following the rejected strobe, for exactly one cycle.
- busy falls on the edge that returns the FSM to IDLE. Total idle-to-idle time for one word is write + 1 cycle + frame length.

## Test plan
- Basic frame:
  - Stimulus: DATA_WIDTH=8, CLKS_PER_BIT=4, write 0xA5, parity_en=1, parity_odd=0, two_stop=0.
  - Response: tx_out = 0, then 1,0,1,0,0,1,0,1, then parity 0, then stop 1; each bit 4 cycles, 44 cycles total; busy high throughout.
- Odd parity, two stop bits:
  - Stimulus: same word with parity_odd=1, two_stop=1.
  - Response: parity bit = 1, stop level held 8 cycles, frame = 48 cycles.
- Back-to-back, no parity:
  - Stimulus: parity_en=0, write 0x00 and 0xFF on consecutive cycles.
  - Response: two 40-cycle frames with no idle gap; busy stays high for 80 cycles; fifo_count returns to 0.
- Overflow:
  - Stimulus: FIFO_DEPTH=4, engine idle, assert data_valid on 6 consecutive cycles.
  - Response: 5 words accepted (1 popped at the second edge, 4 buffered); the 6th is dropped with ready=0 and a one-cycle overflow pulse; the 5 accepted words are transmitted in order.
- Mid-frame reset:
  - Stimulus: assert reset during the DATA state with 2 words queued.
  - Response: tx_out=1, busy=0, fifo_count=0 and ready=1 asynchronously; after release, no transmission until a new write.
- Configuration change mid-frame:
  - Stimulus: toggle parity_en during the DATA state.
  - Response: the current frame keeps its latched setting; the next frame uses the new setting.
